// File: rtl/final_layer_loader.sv
// Byte-serial loader for the final layer's activation and weight operand registers.
// Optional checksum stage enabled by defining FINAL_LOADER_CHECKSUM_EN.
module final_layer_loader #(
    parameter int unsigned NUM_INPUTS  = 196,
    parameter int unsigned NUM_NEURONS = 10
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [7:0]                        in_byte,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_INPUTS-1:0]             data_out,
    output logic [NUM_INPUTS*NUM_NEURONS-1:0] weights_out,
    output logic                              load_done,
    output logic                              busy,
    output logic                              load_error
);

    localparam int unsigned BPV = (NUM_INPUTS + 7) / 8;
    localparam int unsigned CW  = (BPV > 1) ? $clog2(BPV) : 1;
    localparam logic [CW-1:0] LastByte   = CW'(BPV - 1);
    localparam logic [3:0]    LastNeuron = 4'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadData,
        StLoadWeights,
        StCheck,
        StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   byte_cnt_q;
    logic [3:0]      neuron_cnt_q;
    logic            busy_q;
    logic            done_q;

    logic accept;
    logic wr_data;
    logic wr_weights;
    logic last_byte;

    always_comb begin
        in_ready = ((state_q == StLoadData) || (state_q == StLoadWeights) ||
                    (state_q == StCheck)) && !start;
    end

    assign accept     = in_valid && in_ready;
    assign wr_data    = accept && (state_q == StLoadData);
    assign wr_weights = accept && (state_q == StLoadWeights);
    assign last_byte  = (byte_cnt_q == LastByte);

    assign busy      = busy_q;
    assign load_done = done_q;

    // Control FSM; busy/load_done are registered alongside the state so they
    // never see a combinational path from the inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            byte_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (start) begin
            state_q      <= StLoadData;
            byte_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                StLoadData: begin
                    if (accept) begin
                        if (last_byte) begin
                            byte_cnt_q <= '0;
                            state_q    <= StLoadWeights;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                StLoadWeights: begin
                    if (accept) begin
                        if (last_byte) begin
                            byte_cnt_q <= '0;
                            if (neuron_cnt_q == LastNeuron) begin
`ifdef FINAL_LOADER_CHECKSUM_EN
                                state_q <= StCheck;
`else
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                neuron_cnt_q <= neuron_cnt_q + 1'b1;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (accept) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FINAL_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            xor_q   <= '0;
            error_q <= 1'b0;
        end else if (start) begin
            xor_q   <= '0;
            error_q <= 1'b0;
        end else if (wr_data || wr_weights) begin
            xor_q <= xor_q ^ in_byte;
        end else if (accept && (state_q == StCheck)) begin
            error_q <= (in_byte != xor_q);
        end
    end

    assign load_error = error_q;
`else
    assign load_error = 1'b0;
`endif

    // One register per byte lane; the final lane keeps only the bits below
    // NUM_INPUTS, so pad bits of the last byte are simply never stored.
    for (genvar k = 0; k < BPV; k++) begin : g_data
        localparam int unsigned LW = ((NUM_INPUTS - k * 8) >= 8) ? 8 : (NUM_INPUTS - k * 8);
        logic [LW-1:0] lane_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                lane_q <= '0;
            end else if (wr_data && (byte_cnt_q == CW'(k))) begin
                lane_q <= in_byte[LW-1:0];
            end
        end

        assign data_out[k*8 +: LW] = lane_q;
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        for (genvar k = 0; k < BPV; k++) begin : g_lane
            localparam int unsigned LW = ((NUM_INPUTS - k * 8) >= 8) ? 8 : (NUM_INPUTS - k * 8);
            logic [LW-1:0] lane_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    lane_q <= '0;
                end else if (wr_weights && (neuron_cnt_q == 4'(n)) &&
                             (byte_cnt_q == CW'(k))) begin
                    lane_q <= in_byte[LW-1:0];
                end
            end

            assign weights_out[n*NUM_INPUTS + k*8 +: LW] = lane_q;
        end
    end

endmodule

// File: tb/tb_final_layer_loader.sv
// Self-checking bench for final_layer_loader: byte-count reference model plus directed loads.
module tb_final_layer_loader;

    localparam int NI    = 196;
    localparam int NN    = 10;
    localparam int BPV   = (NI + 7) / 8;
    localparam int TOTAL = BPV * (NN + 1);
`ifdef FINAL_LOADER_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    bit              clock;
    logic            reset;
    logic            start;
    logic [7:0]      in_byte;
    logic            in_valid;
    logic            in_ready;
    logic [NI-1:0]   data_out;
    logic [NI*NN-1:0] weights_out;
    logic            load_done;
    logic            busy;
    logic            load_error;

    final_layer_loader #(
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .weights_out(weights_out),
        .load_done  (load_done),
        .busy       (busy),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 streaming payload, 2 awaiting checksum, 3 done.
    int              m_phase = 0;
    int              m_count = 0;
    logic [NI-1:0]   m_data  = '0;
    logic [NI*NN-1:0] m_w    = '0;
    logic            m_err   = 1'b0;
    logic [7:0]      m_xor   = '0;

    task automatic put_byte(input int p, input logic [7:0] v);
        int n;
        int k;
        int idx;
        if (p < BPV) begin
            n = -1;
            k = p;
        end else begin
            n = (p - BPV) / BPV;
            k = (p - BPV) % BPV;
        end
        for (int b = 0; b < 8; b++) begin
            idx = k * 8 + b;
            if (idx < NI) begin
                if (n < 0) m_data[idx] = v[b];
                else       m_w[n*NI + idx] = v[b];
            end
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0;
            m_count = 0;
            m_data  = '0;
            m_w     = '0;
            m_err   = 1'b0;
            m_xor   = '0;
        end else if (start) begin
            m_phase = 1;
            m_count = 0;
            m_err   = 1'b0;
            m_xor   = '0;
        end else if (in_valid && m_phase == 1) begin
            put_byte(m_count, in_byte);
            m_xor = m_xor ^ in_byte;
            m_count++;
            if (m_count == TOTAL) m_phase = (CHK != 0) ? 2 : 3;
        end else if (in_valid && m_phase == 2) begin
            m_err   = (in_byte != m_xor);
            m_phase = 3;
        end
    end

    always @(negedge clock) begin
        check("in_ready", 256'(in_ready), 256'((m_phase == 1 || m_phase == 2) && !start));
        check("busy", 256'(busy), 256'(m_phase == 1 || m_phase == 2));
        check("load_done", 256'(load_done), 256'(m_phase == 3));
        check("load_error", 256'(load_error), 256'(m_err));
        if (m_phase == 0 || m_phase == 3) begin
            check("data_out", 256'(data_out), 256'(m_data));
            for (int n = 0; n < NN; n++)
                check($sformatf("weights_n%0d", n), 256'(weights_out[n*NI +: NI]),
                      256'(m_w[n*NI +: NI]));
        end
    end

    function automatic logic [7:0] pay(input int mode, input int p);
        case (mode)
            0:       return (p < BPV) ? 8'hA5 : 8'((p - BPV) / BPV);
            1:       return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    // Entered and left at posedge+1. Stops early (in_valid left high) when abort_at is reached.
    task automatic run_load(input int mode, input bit bp, input int abort_at,
                            input logic [7:0] chk, output int edges);
        int p = 0;
        int c = 0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h00;
        @(posedge clock);
        #1;
        start = 1'b0;
        edges = 0;
        while (p < TOTAL) begin
            if (p == abort_at) return;
            in_valid = bp ? (c % 3 == 0) : 1'b1;
            in_byte  = pay(mode, p);
            @(posedge clock);
            edges++;
            if (in_valid) p++;
            c++;
            #1;
        end
        if (CHK != 0) begin
            in_valid = 1'b1;
            in_byte  = chk;
            @(posedge clock);
            edges++;
            #1;
        end
        in_valid = 1'b0;
    endtask

    logic [NI-1:0] exp_a5;
    logic [NI-1:0] exp_n;
    int            edges;

    task automatic check_pattern0(input string tag);
        check({tag, "_data"}, 256'(data_out), 256'(exp_a5));
        for (int n = 0; n < NN; n += 3) begin
            exp_n = {4'(n), {24{8'(n)}}};
            check($sformatf("%s_w%0d", tag, n), 256'(weights_out[n*NI +: NI]), 256'(exp_n));
        end
    endtask

    initial begin
        exp_a5   = {4'h5, {24{8'hA5}}};
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle with valid data but no start: nothing accepted.
        in_valid = 1'b1;
        in_byte  = 8'h77;
        repeat (4) @(posedge clock);
        #1;
        check("idle_in_ready", 256'(in_ready), 256'(0));
        check("idle_data", 256'(data_out), 256'(0));
        in_valid = 1'b0;

        // Full load, continuous valid.
        run_load(0, 1'b0, -1, 8'h00, edges);
        check("cont_latency", 256'(edges), 256'(275 + CHK));
        check("cont_done", 256'(load_done), 256'(1));
        check_pattern0("cont");
        repeat (3) @(posedge clock);
        #1;
        check("cont_hold", 256'(data_out), 256'(exp_a5));

        // Backpressure: valid 1,0,0 repeating -> 548 idle cycles.
        run_load(0, 1'b1, -1, 8'h00, edges);
        check("bp_latency", 256'(edges), 256'(823 + CHK));
        check("bp_done", 256'(load_done), 256'(1));
        check_pattern0("bp");

        // Restart after 100 accepts, then a full 0xFF load.
        run_load(0, 1'b0, 100, 8'h00, edges);
        run_load(1, 1'b0, -1, 8'h00, edges);
        check("rst_latency", 256'(edges), 256'(275 + CHK));
        check("ones_data", 256'(data_out), 256'({NI{1'b1}}));
        check("ones_weights", 256'(&weights_out), 256'(1));

        // Mid-load reset after 50 accepts.
        run_load(0, 1'b0, 50, 8'h00, edges);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("mr_busy", 256'(busy), 256'(0));
        check("mr_data", 256'(data_out), 256'(0));
        check("mr_weights", 256'(|weights_out), 256'(0));

`ifdef FINAL_LOADER_CHECKSUM_EN
        run_load(2, 1'b0, -1, 8'h01, edges);
        check("ck_good_err", 256'(load_error), 256'(0));
        check("ck_good_done", 256'(load_done), 256'(1));
        run_load(2, 1'b0, -1, 8'h00, edges);
        check("ck_bad_err", 256'(load_error), 256'(1));
        check("ck_bad_done", 256'(load_done), 256'(1));
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ck_clear_err", 256'(load_error), 256'(0));
        check("ck_clear_done", 256'(load_done), 256'(0));
`else
        run_load(2, 1'b0, -1, 8'h00, edges);
        check("nock_err", 256'(load_error), 256'(0));
        check("nock_data", 256'(data_out), 256'({4'h1, {24{8'h01}}}));
`endif

        repeat (2) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
